// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN image stream buffer: register map,
// STATUS/CTRL bit positions and the buffer state encoding.
package cnn_pkg;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_PIXDATA = 2'd2;
   localparam logic [1:0] ADDR_ROWCNT  = 2'd3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVF  = 2;
   localparam int STAT_ERR  = 3;

   localparam int CTRL_START = 0;
   localparam int CTRL_CLEAR = 1;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } img_state_t;

endpackage

// File: rtl/cnn_img_stream_if.sv
// Bus bundle for cnn_img_stream: Avalon-MM slave side plus the pixel stream.
// Stream handshake: a beat transfers on a rising edge where pix_valid & pix_ready;
// once pix_valid is high, data and markers hold until that transfer happens.
interface cnn_img_stream_if #(
   parameter int DATA_W = 8
);
   logic              chipselect;
   logic              write;
   logic              read;
   logic [1:0]        address;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_sof;
   logic              pix_eol;
   logic              pix_eof;

   modport slave (
      input  chipselect, write, read, address, writedata, pix_ready,
      output readdata, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
   );

   modport master (
      output chipselect, write, read, address, writedata, pix_ready,
      input  readdata, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
   );
endinterface

// File: rtl/cnn_pix_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port with
// read enable. The array has no reset so it maps onto block RAM.
module cnn_pix_ram
   import cnn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 784,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/cnn_img_stream.sv
// Avalon-MM image buffer: HPS loads one frame byte-by-byte, START streams it
// in raster order with sof/eol/eof markers through a RAM stage and an output register.
module cnn_img_stream
   import cnn_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   cnn_img_stream_if.slave bus,
   output logic        done_irq,
   output img_state_t  state_o
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   // Pointers must be able to hold NPIX itself, even when NPIX is a power of two.
   localparam int PW   = $clog2(NPIX + 1);
   localparam logic [PW-1:0] NPIX_P  = PW'(NPIX);
   localparam logic [7:0]    LAST_C  = 8'(IMG_W - 1);
   localparam logic [7:0]    LAST_R  = 8'(IMG_H - 1);

   img_state_t        state_q;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [7:0]        wr_col_q, wr_row_q, rd_col_q, rd_row_q;
   logic              err_q, ovf_q;
   logic              s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
   logic              pix_valid_q, pix_sof_q, pix_eol_q, pix_eof_q;
   logic [DATA_W-1:0] pix_data_q, readdata_q, ram_rdata;
   logic [DATA_W-1:0] status_d;

   logic wr_acc, ctrl_wr, clear, start, start_go, pix_wr, full, ram_we;
   logic advance, issue, accept;

   assign wr_acc   = bus.chipselect & bus.write;
   assign ctrl_wr  = wr_acc && (bus.address == ADDR_CTRL);
   assign clear    = ctrl_wr & bus.writedata[CTRL_CLEAR];
   assign start    = ctrl_wr & bus.writedata[CTRL_START] & ~clear;
   assign full     = (wr_ptr_q == NPIX_P);
   assign start_go = start && (state_q == LOAD) && full;
   assign pix_wr   = wr_acc && (bus.address == ADDR_PIXDATA);
   assign ram_we   = pix_wr && (state_q == LOAD) && !full;
   assign accept   = pix_valid_q & bus.pix_ready;
   assign advance  = !pix_valid_q | bus.pix_ready;
   // Issuing in the START cycle itself gives first valid two cycles after START.
   assign issue    = advance && !clear && (rd_ptr_q < NPIX_P) &&
                     ((state_q == STREAM) || start_go);

   cnn_pix_ram #(.DATA_W(DATA_W), .DEPTH(NPIX), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (bus.writedata),
      .re_i    (issue),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= LOAD;
         wr_ptr_q    <= '0;
         wr_col_q    <= '0;
         wr_row_q    <= '0;
         rd_ptr_q    <= '0;
         rd_col_q    <= '0;
         rd_row_q    <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eol_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_sof_q   <= 1'b0;
         pix_eol_q   <= 1'b0;
         pix_eof_q   <= 1'b0;
         pix_data_q  <= '0;
      end else if (clear) begin
         state_q     <= LOAD;
         wr_ptr_q    <= '0;
         wr_col_q    <= '0;
         wr_row_q    <= '0;
         rd_ptr_q    <= '0;
         rd_col_q    <= '0;
         rd_row_q    <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         pix_valid_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (start_go)   state_q <= STREAM;
               else if (start) err_q   <= 1'b1;
            end
            STREAM:  if (accept && pix_eof_q) state_q <= DONE;
            default: ;
         endcase

         if (pix_wr) begin
            if (state_q != LOAD) begin
               err_q <= 1'b1;
            end else if (full) begin
               ovf_q <= 1'b1;
            end else begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
               if (wr_col_q == LAST_C) begin
                  wr_col_q <= '0;
                  wr_row_q <= wr_row_q + 1'b1;
               end else begin
                  wr_col_q <= wr_col_q + 1'b1;
               end
            end
         end

         // Both pipeline stages move together; a stall freezes RAM output and output register.
         if (advance) begin
            pix_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               pix_data_q <= ram_rdata;
               pix_sof_q  <= s1_sof_q;
               pix_eol_q  <= s1_eol_q;
               pix_eof_q  <= s1_eof_q;
            end
            s1_valid_q <= issue;
            if (issue) begin
               s1_sof_q <= (rd_ptr_q == '0);
               s1_eol_q <= (rd_col_q == LAST_C);
               s1_eof_q <= (rd_col_q == LAST_C) && (rd_row_q == LAST_R);
               rd_ptr_q <= rd_ptr_q + 1'b1;
               if (rd_col_q == LAST_C) begin
                  rd_col_q <= '0;
                  rd_row_q <= rd_row_q + 1'b1;
               end else begin
                  rd_col_q <= rd_col_q + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      status_d            = '0;
      status_d[STAT_BUSY] = (state_q == STREAM);
      status_d[STAT_DONE] = (state_q == DONE);
      status_d[STAT_OVF]  = ovf_q;
      status_d[STAT_ERR]  = err_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdata_q <= '0;
      end else if (bus.chipselect && bus.read) begin
         case (bus.address)
            ADDR_STATUS: readdata_q <= status_d;
            ADDR_ROWCNT: readdata_q <= DATA_W'(wr_row_q);
            default:     readdata_q <= '0;
         endcase
      end
   end

   assign bus.readdata  = readdata_q;
   assign bus.pix_data  = pix_data_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_sof   = pix_sof_q;
   assign bus.pix_eol   = pix_eol_q;
   assign bus.pix_eof   = pix_eof_q;
   assign done_irq      = (state_q == DONE);
   assign state_o       = state_q;

endmodule

// File: tb/tb_cnn_img_stream.sv
// Directed bench for cnn_img_stream: loads frames over Avalon, checks the
// streamed beats against an expected queue, and exercises clear/overflow/reset paths.
module tb_cnn_img_stream;
   import cnn_pkg::*;

   localparam int W = 28;
   localparam int H = 28;
   localparam int N = W * H;

   logic       clk;
   logic       rst_n;
   logic       done_irq;
   img_state_t state_o;

   cnn_img_stream_if #(.DATA_W(8)) bus ();

   cnn_img_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .bus      (bus),
      .done_irq (done_irq),
      .state_o  (state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q [$];
   int          beat_cnt = 0;
   logic [7:0]  last_data = 8'h00;
   logic        stall_pend = 1'b0;
   logic [31:0] stall_val = '0;
   int          ready_mode = 0;   // 0: low, 1: high, 2: random

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix_val(input int i, input int mode);
      if (mode == 0) return 8'(i % 256);
      return 8'((i * 3 + 7) % 256);
   endfunction

   task automatic push_frame(input int mode);
      for (int i = 0; i < N; i++)
         exp_q.push_back({21'd0, (i == 0), ((i % W) == W - 1), (i == N - 1), pix_val(i, mode)});
   endtask

   always @(negedge clk) begin
      logic [31:0] cur;
      cur = {21'd0, bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_data};
      if (stall_pend && bus.pix_valid) chk("stall_hold", cur, stall_val);
      stall_pend = bus.pix_valid && !bus.pix_ready;
      stall_val  = cur;
      if (bus.pix_valid && bus.pix_ready) begin
         beat_cnt++;
         last_data = bus.pix_data;
         if (exp_q.size() == 0) chk("extra_beat", cur, 32'hDEAD);
         else chk("beat", cur, exp_q.pop_front());
      end
   end

   initial begin
      bus.pix_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.pix_ready = 1'b0;
            1:       bus.pix_ready = 1'b1;
            default: bus.pix_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic av_write(input logic [1:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.address    = addr;
      bus.writedata  = data;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
   endtask

   task automatic av_read(input logic [1:0] addr, output logic [7:0] data);
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = addr;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      data = bus.readdata;
   endtask

   task automatic load_img(input int n, input int mode);
      for (int i = 0; i < n; i++) av_write(ADDR_PIXDATA, pix_val(i, mode));
   endtask

   task automatic wait_drain(input int budget);
      for (int c = 0; c < budget; c++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] rd;
      logic       saw_valid;

      rst_n = 1'b0;
      bus.chipselect = 1'b0;
      bus.write = 1'b0;
      bus.read = 1'b0;
      bus.address = 2'd0;
      bus.writedata = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_valid", bus.pix_valid, 0);
      chk("rst_readdata", bus.readdata, 0);
      chk("rst_done_irq", done_irq, 0);
      chk("rst_state", state_o, LOAD);
      av_read(ADDR_STATUS, rd);
      chk("rst_status", rd, 8'h00);

      // 1: full frame, ready held high
      ready_mode = 1;
      load_img(N, 0);
      av_read(ADDR_ROWCNT, rd);
      chk("t1_rowcnt", rd, 28);
      av_read(ADDR_CTRL, rd);
      chk("t1_ctrl_rd", rd, 8'h00);
      push_frame(0);
      av_write(ADDR_CTRL, 8'h01);
      chk("t1_lat0", bus.pix_valid, 0);
      @(negedge clk);
      chk("t1_lat1", bus.pix_valid, 0);
      @(negedge clk);
      chk("t1_lat2", bus.pix_valid, 1);
      wait_drain(2000);
      repeat (2) @(negedge clk);
      av_read(ADDR_STATUS, rd);
      chk("t1_status", rd, 8'h02);
      chk("t1_done_irq", done_irq, 1);
      chk("t1_last", last_data, 8'h0F);

      // 2: same frame, random backpressure
      av_write(ADDR_CTRL, 8'h02);
      av_read(ADDR_STATUS, rd);
      chk("t2_clr_status", rd, 8'h00);
      load_img(N, 0);
      push_frame(0);
      ready_mode = 2;
      av_write(ADDR_CTRL, 8'h01);
      wait_drain(8000);
      ready_mode = 1;
      repeat (3) @(negedge clk);
      av_read(ADDR_STATUS, rd);
      chk("t2_status", rd, 8'h02);

      // 3: short image, START refused
      av_write(ADDR_CTRL, 8'h02);
      load_img(100, 0);
      av_write(ADDR_CTRL, 8'h01);
      saw_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_valid = saw_valid | bus.pix_valid;
      end
      chk("t3_no_valid", saw_valid, 0);
      av_read(ADDR_STATUS, rd);
      chk("t3_status", rd, 8'h08);
      av_read(ADDR_ROWCNT, rd);
      chk("t3_rowcnt", rd, 3);

      // 4: overflow byte dropped
      av_write(ADDR_CTRL, 8'h02);
      load_img(N + 1, 0);
      av_read(ADDR_STATUS, rd);
      chk("t4_status_ovf", rd, 8'h04);
      push_frame(0);
      beat_cnt = 0;
      av_write(ADDR_CTRL, 8'h01);
      wait_drain(2000);
      repeat (2) @(negedge clk);
      chk("t4_beats", beat_cnt, N);
      chk("t4_last", last_data, 8'h0F);
      av_read(ADDR_STATUS, rd);
      chk("t4_status_end", rd, 8'h06);
      av_write(ADDR_PIXDATA, 8'h55);
      av_read(ADDR_STATUS, rd);
      chk("t4_status_err", rd, 8'h0E);

      // 5: clear mid-stream, then reload with new data
      av_write(ADDR_CTRL, 8'h02);
      load_img(N, 0);
      push_frame(0);
      beat_cnt = 0;
      av_write(ADDR_CTRL, 8'h01);
      for (int c = 0; c < 2000 && beat_cnt < 300; c++) @(negedge clk);
      chk("t5_reach300", beat_cnt >= 300, 1);
      av_write(ADDR_CTRL, 8'h02);
      chk("t5_valid_drop", bus.pix_valid, 0);
      exp_q.delete();
      av_read(ADDR_STATUS, rd);
      chk("t5_status", rd, 8'h00);
      av_read(ADDR_ROWCNT, rd);
      chk("t5_rowcnt", rd, 0);
      load_img(N, 1);
      push_frame(1);
      av_write(ADDR_CTRL, 8'h03);   // clear wins over start
      @(negedge clk);
      @(negedge clk);
      chk("t5_clr_prio", bus.pix_valid, 0);
      av_read(ADDR_STATUS, rd);
      chk("t5_prio_status", rd, 8'h00);
      load_img(N, 1);
      av_write(ADDR_CTRL, 8'h01);
      wait_drain(2000);

      // 6: asynchronous reset mid-stream
      av_write(ADDR_CTRL, 8'h02);
      load_img(N, 0);
      push_frame(0);
      beat_cnt = 0;
      av_write(ADDR_CTRL, 8'h01);
      for (int c = 0; c < 500 && beat_cnt < 50; c++) @(negedge clk);
      chk("t6_streaming", bus.pix_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", bus.pix_valid, 0);
      chk("t6_outs", {bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_data}, 0);
      chk("t6_done_irq", done_irq, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_state", state_o, LOAD);
      av_write(ADDR_CTRL, 8'h01);
      av_read(ADDR_STATUS, rd);
      chk("t6_status_err", rd, 8'h08);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
